// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard event controller:
// scan codes, FSM state encoding and event/status/modifier bit positions.
package kbd_pkg;

    localparam logic [7:0] PFX_E0    = 8'hE0;
    localparam logic [7:0] PFX_F0    = 8'hF0;
    localparam logic [7:0] PFX_E1    = 8'hE1;
    localparam logic [7:0] BAT_OK    = 8'hAA;
    localparam logic [7:0] BAT_FAIL  = 8'hFC;
    localparam logic [7:0] ACK       = 8'hFA;
    localparam logic [7:0] ECHO      = 8'hEE;
    localparam logic [7:0] OVR0      = 8'h00;
    localparam logic [7:0] OVR1      = 8'hFF;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    // Event word layout: {extended, release, scan code}
    localparam int EVT_W   = 10;
    localparam int EVT_EXT = 9;
    localparam int EVT_REL = 8;

    localparam int STAT_OVF   = 0;
    localparam int STAT_SEQ   = 1;
    localparam int STAT_BOK   = 2;
    localparam int STAT_BFAIL = 3;

    localparam int MOD_LSHIFT = 0;
    localparam int MOD_RSHIFT = 1;
    localparam int MOD_CTRL   = 2;
    localparam int MOD_ALT    = 3;

    // Bytes swallowed after an E1 prefix before the pause event is emitted
    localparam logic [2:0] E1_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_E1SKIP
    } kbd_state_t;

    function automatic logic [EVT_W-1:0] make_evt(input logic       ext,
                                                  input logic       rel,
                                                  input logic [7:0] code);
        return {ext, rel, code};
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// First-word-fall-through event FIFO; the head word is visible combinationally
// and the last popped word is held on the output while the FIFO is empty.
module kbd_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    // A pop frees the slot this same edge, so a push into a full FIFO is accepted.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code sequencer: decodes E0/F0/E1 prefix streams into key events,
// queues them in a FWFT FIFO and tracks modifier and sticky status state.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kbd_rda,
    input  logic [7:0]              kbd_byte,
    output logic                    evt_valid,
    output logic [9:0]              evt_data,
    input  logic                    evt_ack,
    output logic [$clog2(DEPTH):0]  evt_count,
    output logic [3:0]              mods,
    output logic [3:0]              stat,
    input  logic                    stat_clr
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    kbd_state_t     r_state;
    kbd_state_t     w_state_next;
    logic           r_rda_d;
    logic [TW-1:0]  r_tmo;
    logic [2:0]     r_skip;
    logic [2:0]     w_skip_next;
    logic [3:0]     r_mods;
    logic [3:0]     w_mods_next;
    logic [3:0]     r_stat;
    logic [3:0]     w_dec_set;

    logic             w_strb;
    logic             w_push;
    logic [EVT_W-1:0] w_push_data;
    logic             w_full;
    logic             w_empty;
    logic             w_fifo_drop;
    logic             w_tmo_hit;

    assign w_strb    = kbd_rda & ~r_rda_d;
    assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo == TMO_LAST);

    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip;
        w_push       = 1'b0;
        w_push_data  = '0;
        w_dec_set    = '0;
        if (w_strb) begin
            case (r_state)
                ST_IDLE: begin
                    case (kbd_byte)
                        PFX_E0:     w_state_next = ST_E0;
                        PFX_F0:     w_state_next = ST_F0;
                        PFX_E1: begin
                            w_state_next = ST_E1SKIP;
                            w_skip_next  = E1_SKIP_LEN;
                        end
                        BAT_OK:     w_dec_set[STAT_BOK]   = 1'b1;
                        BAT_FAIL:   w_dec_set[STAT_BFAIL] = 1'b1;
                        OVR0, OVR1: w_dec_set[STAT_OVF]   = 1'b1;
                        ACK, ECHO:  w_push = 1'b0;
                        default: begin
                            w_push      = 1'b1;
                            w_push_data = make_evt(1'b0, 1'b0, kbd_byte);
                        end
                    endcase
                end
                ST_E0: begin
                    if (kbd_byte == PFX_F0) begin
                        w_state_next = ST_E0F0;
                    end else if (kbd_byte == PFX_E0) begin
                        w_dec_set[STAT_SEQ] = 1'b1;
                    end else begin
                        // E0 12 is the fake shift the keyboard wraps around
                        // extended keys; it carries no information.
                        w_state_next = ST_IDLE;
                        if (kbd_byte != SC_LSHIFT) begin
                            w_push      = 1'b1;
                            w_push_data = make_evt(1'b1, 1'b0, kbd_byte);
                        end
                    end
                end
                ST_F0: begin
                    w_state_next = ST_IDLE;
                    if (kbd_byte == PFX_F0 || kbd_byte == PFX_E0) begin
                        w_dec_set[STAT_SEQ] = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = make_evt(1'b0, 1'b1, kbd_byte);
                    end
                end
                ST_E0F0: begin
                    w_state_next = ST_IDLE;
                    if (kbd_byte != SC_LSHIFT) begin
                        w_push      = 1'b1;
                        w_push_data = make_evt(1'b1, 1'b1, kbd_byte);
                    end
                end
                ST_E1SKIP: begin
                    w_skip_next = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_next = ST_IDLE;
                        w_push       = 1'b1;
                        w_push_data  = make_evt(1'b1, 1'b0, PFX_E1);
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_next        = ST_IDLE;
            w_dec_set[STAT_SEQ] = 1'b1;
        end
    end

    // Modifier state follows decoded events, whether or not the FIFO has room.
    always_comb begin
        w_mods_next = r_mods;
        if (w_push) begin
            case (w_push_data[7:0])
                SC_LSHIFT: if (!w_push_data[EVT_EXT]) w_mods_next[MOD_LSHIFT] = ~w_push_data[EVT_REL];
                SC_RSHIFT: if (!w_push_data[EVT_EXT]) w_mods_next[MOD_RSHIFT] = ~w_push_data[EVT_REL];
                SC_CTRL:   w_mods_next[MOD_CTRL] = ~w_push_data[EVT_REL];
                SC_ALT:    w_mods_next[MOD_ALT]  = ~w_push_data[EVT_REL];
                default:   w_mods_next = r_mods;
            endcase
        end
    end

    assign w_fifo_drop = w_push & w_full & ~evt_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rda_d <= 1'b1;
            r_tmo   <= '0;
            r_skip  <= '0;
            r_mods  <= '0;
            r_stat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_rda_d <= kbd_rda;
            r_skip  <= w_skip_next;
            r_mods  <= w_mods_next;
            if (w_strb || r_state == ST_IDLE || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            r_stat <= (stat_clr ? 4'b0000 : r_stat) | w_dec_set | {3'b000, w_fifo_drop};
        end
    end

    kbd_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (evt_ack),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (evt_count),
        .o_head      (evt_data)
    );

    assign evt_valid = ~w_empty;
    assign mods      = r_mods;
    assign stat      = r_stat;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Randomized scoreboard bench for kbd_event_ctrl with a byte-sequence
// reference model and a decoupled output monitor.
module tb_kbd_event_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       kbd_rda;
    logic [7:0] kbd_byte;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       evt_ack;
    logic [3:0] evt_count;
    logic [3:0] mods;
    logic [3:0] stat;
    logic       stat_clr;

    always #5 clk = ~clk;

    kbd_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_rda   (kbd_rda),
        .kbd_byte  (kbd_byte),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ack   (evt_ack),
        .evt_count (evt_count),
        .mods      (mods),
        .stat      (stat),
        .stat_clr  (stat_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit ack_en   = 0;

    // Reference model state
    logic [9:0] exp_q[$];
    logic [7:0] pend[$];
    int         m_occ  = 0;
    int         m_idle = 0;
    logic [3:0] m_mods = 0;
    logic [3:0] m_stat = 0;
    logic       m_rda_prev = 1'b1;
    logic [3:0] m_set;
    logic       m_have;
    logic       m_pop;
    logic [9:0] m_ev;
    logic [7:0] m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: interprets the byte history accumulated since the last complete event.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend.delete();
            m_occ = 0; m_idle = 0; m_mods = 0; m_stat = 0; m_rda_prev = 1'b1;
        end else begin
            m_set = 0; m_have = 0; m_ev = 0;
            m_pop = evt_ack && (m_occ > 0);
            m_b = kbd_byte;
            if (kbd_rda && !m_rda_prev) begin
                m_idle = 0;
                if (pend.size() == 0) begin
                    if (m_b == 8'hE0 || m_b == 8'hF0 || m_b == 8'hE1) pend.push_back(m_b);
                    else if (m_b == 8'hAA) m_set[2] = 1;
                    else if (m_b == 8'hFC) m_set[3] = 1;
                    else if (m_b == 8'h00 || m_b == 8'hFF) m_set[0] = 1;
                    else if (m_b != 8'hFA && m_b != 8'hEE) begin m_have = 1; m_ev = {2'b00, m_b}; end
                end else if (pend[0] == 8'hE1) begin
                    pend.push_back(m_b);
                    if (pend.size() == 8) begin m_have = 1; m_ev = {2'b10, 8'hE1}; pend.delete(); end
                end else if (pend[0] == 8'hF0) begin
                    pend.delete();
                    if (m_b == 8'hE0 || m_b == 8'hF0) m_set[1] = 1;
                    else begin m_have = 1; m_ev = {2'b01, m_b}; end
                end else if (pend.size() == 1) begin
                    if (m_b == 8'hF0) pend.push_back(m_b);
                    else if (m_b == 8'hE0) m_set[1] = 1;
                    else begin
                        pend.delete();
                        if (m_b != 8'h12) begin m_have = 1; m_ev = {2'b10, m_b}; end
                    end
                end else begin
                    pend.delete();
                    if (m_b != 8'h12) begin m_have = 1; m_ev = {2'b11, m_b}; end
                end
            end else if (pend.size() > 0) begin
                m_idle++;
                if (m_idle == TMO) begin pend.delete(); m_set[1] = 1; m_idle = 0; end
            end
            if (m_have) begin
                if (m_ev[7:0] == 8'h12 && !m_ev[9]) m_mods[0] = !m_ev[8];
                if (m_ev[7:0] == 8'h59 && !m_ev[9]) m_mods[1] = !m_ev[8];
                if (m_ev[7:0] == 8'h14) m_mods[2] = !m_ev[8];
                if (m_ev[7:0] == 8'h11) m_mods[3] = !m_ev[8];
                if (m_occ < DEPTH || m_pop) begin exp_q.push_back(m_ev); m_occ++; end
                else m_set[0] = 1;
            end
            if (m_pop) m_occ--;
            m_stat = (stat_clr ? 4'b0000 : m_stat) | m_set;
            m_rda_prev = kbd_rda;
        end
    end

    // Monitor: compares the presented head and live state, pops on accepted ack.
    always @(negedge clk) begin
        if (!rst) begin
            check("evt_valid", {31'b0, evt_valid}, {31'b0, m_occ != 0});
            check("evt_count", {28'b0, evt_count}, m_occ);
            check("mods", {28'b0, mods}, {28'b0, m_mods});
            check("stat", {28'b0, stat}, {28'b0, m_stat});
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    check("head_unexpected", {22'b0, evt_data}, 32'hFFFF_FFFF);
                end else begin
                    check("head", {22'b0, evt_data}, {22'b0, exp_q[0]});
                    if (evt_ack) begin
                        $display("event %03h popped", evt_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic rda, input logic [7:0] b, input logic force_ack, input logic clr);
        kbd_rda  = rda;
        kbd_byte = b;
        evt_ack  = force_ack | (ack_en && ($urandom_range(0, 1) == 1));
        stat_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0);
        cyc(1'b1, b, 1'b0, 1'b0);
        cyc(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_occ > 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("drained_count", {28'b0, evt_count}, 0);
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h11, 8'h1C,
                              8'h75, 8'hAA, 8'hFC, 8'h00, 8'hFF, 8'hFA, 8'hEE, 8'h2B};

    initial begin
        rst = 1; kbd_rda = 1; kbd_byte = 8'h1C; evt_ack = 0; stat_clr = 0;
        @(posedge clk); #1;
        repeat (3) cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        rst = 0;
        // rda still high after reset must not count as a new byte
        repeat (3) cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        check("rst_valid", {31'b0, evt_valid}, 0);
        check("rst_data", {22'b0, evt_data}, 0);
        check("rst_count", {28'b0, evt_count}, 0);
        check("rst_mods", {28'b0, mods}, 0);
        check("rst_stat", {28'b0, stat}, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        ack_en = 0;
        cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        check("valid_one_clk_after_strb", {31'b0, evt_valid}, 1);
        cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        cyc(1'b0, 8'h1C, 1'b0, 1'b0);
        send(8'hF0); send(8'h1C);
        check("two_events_count", {28'b0, evt_count}, 2);
        check("first_head", {22'b0, evt_data}, 10'h01C);
        drain();

        ack_en = 1;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h12); send(8'h14); send(8'hF0); send(8'h12);
        send(8'hE0); send(8'h12);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain();

        send(8'hAA); send(8'h00); send(8'hE0); idle(TMO + 3);
        check("stat_after_timeout", {28'b0, stat}, 32'h7);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("stat_cleared", {28'b0, stat}, 0);

        ack_en = 0;
        for (int i = 0; i <= DEPTH; i++) send(8'h20 + 8'(i));
        check("full_count", {28'b0, evt_count}, DEPTH);
        check("full_ovf", {28'b0, stat}, 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        check("push_pop_full_count", {28'b0, evt_count}, DEPTH);
        check("push_pop_full_no_ovf", {28'b0, stat}, 0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 8'h3C, 1'b0, 1'b0);
        drain();

        ack_en = 1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = pool[$urandom_range(0, 15)];
            if (b == 8'h2B) b = 8'($urandom_range(0, 255));
            send(b);
            if ($urandom_range(0, 29) == 0) idle(TMO + 2);
            if ($urandom_range(0, 19) == 0) cyc(1'b0, 8'h00, 1'b0, 1'b1);
            if ($urandom_range(0, 49) == 0) ack_en = !ack_en;
        end
        ack_en = 1;
        idle(TMO + 2);
        drain();

        send(8'h14); send(8'hE0);
        rst = 1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("midrst_valid", {31'b0, evt_valid}, 0);
        check("midrst_data", {22'b0, evt_data}, 0);
        check("midrst_count", {28'b0, evt_count}, 0);
        check("midrst_mods", {28'b0, mods}, 0);
        check("midrst_stat", {28'b0, stat}, 0);
        rst = 0;
        ack_en = 0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        send(8'h1C);
        check("after_rst_head", {22'b0, evt_data}, 10'h01C);
        check("after_rst_count", {28'b0, evt_count}, 1);
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
